// File: rtl/canvas_pkg.sv
// Shared types and defaults for the 28x28 drawing canvas: cell/array types,
// painter FSM states, saturating ink add and pixel-to-cell compare ladder.
package canvas_pkg;

  localparam int CANVAS_N    = 28;
  localparam int X0_DEF      = 200;
  localparam int Y0_DEF      = 44;
  localparam int CELL_PX_DEF = 14;

  localparam logic [15:0] INK_CENTER_DEF = 16'h0400;
  localparam logic [15:0] INK_EDGE_DEF   = 16'h0100;
  localparam logic [15:0] INK_MAX_DEF    = 16'h07FF;

  typedef logic [15:0] cell_t;
  typedef cell_t canvas_t [27:0][27:0];

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_CENTER,
    ST_LEFT,
    ST_RIGHT,
    ST_UP,
    ST_DOWN
  } paint_state_t;

  // Sum is one bit wider than a cell so the clamp sees true overflow.
  function automatic cell_t sat_add(input cell_t old_v, input cell_t ink, input cell_t max_v);
    logic [16:0] sum;
    sum = {1'b0, old_v} + {1'b0, ink};
    return (sum > {1'b0, max_v}) ? max_v : sum[15:0];
  endfunction

  function automatic logic [4:0] cell_index(input logic [31:0] off, input int cell_px);
    logic [4:0] idx;
    idx = '0;
    for (int k = 1; k < CANVAS_N; k++) begin
      if (off >= 32'(k * cell_px)) idx = 5'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/canvas_pixel_to_cell.sv
// Maps a screen coordinate to a canvas cell with a compare ladder (no divider).
// Purely combinational so the color mapper can share it.
module pixel_to_cell
  import canvas_pkg::*;
#(
  parameter int X0      = X0_DEF,
  parameter int Y0      = Y0_DEF,
  parameter int CELL_PX = CELL_PX_DEF
) (
  input  logic [9:0] i_ball_x,
  input  logic [9:0] i_ball_y,
  output logic [4:0] o_cx,
  output logic [4:0] o_cy,
  output logic       o_valid
);

  localparam int X_END = X0 + CANVAS_N * CELL_PX;
  localparam int Y_END = Y0 + CANVAS_N * CELL_PX;

  logic [31:0] w_bx;
  logic [31:0] w_by;
  logic [31:0] w_off_x;
  logic [31:0] w_off_y;

  assign w_bx    = {22'd0, i_ball_x};
  assign w_by    = {22'd0, i_ball_y};
  assign w_off_x = w_bx - 32'(X0);
  assign w_off_y = w_by - 32'(Y0);

  assign o_valid = (w_bx >= 32'(X0)) && (w_bx < 32'(X_END)) &&
                   (w_by >= 32'(Y0)) && (w_by < 32'(Y_END));

  assign o_cx = cell_index(w_off_x, CELL_PX);
  assign o_cy = cell_index(w_off_y, CELL_PX);

endmodule

// File: rtl/canvas_painter.sv
// Canvas writer: once per frame inks the cursor cell and its four neighbours
// with saturation, and sweeps the canvas to zero on a clear request.
module canvas_painter
  import canvas_pkg::*;
#(
  parameter int    X0         = X0_DEF,
  parameter int    Y0         = Y0_DEF,
  parameter int    CELL_PX    = CELL_PX_DEF,
  parameter cell_t INK_CENTER = INK_CENTER_DEF,
  parameter cell_t INK_EDGE   = INK_EDGE_DEF,
  parameter cell_t INK_MAX    = INK_MAX_DEF
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [9:0] BallX,
  input  logic [9:0] BallY,
  input  logic       draw_en,
  input  logic       clear_req,
  output canvas_t    canvas,
  output logic       busy
);

  paint_state_t r_state;
  paint_state_t w_next_state;

  logic       r_fc_q;
  logic       w_frame_rise;
  logic [4:0] r_px;
  logic [4:0] r_py;
  logic [4:0] r_col;
  logic       r_pending;
  logic       r_busy;
  canvas_t    r_canvas;

  logic [4:0] w_cx;
  logic [4:0] w_cy;
  logic       w_valid;
  logic       w_stroke;

  logic       w_wr_en;
  logic [4:0] w_wr_x;
  logic [4:0] w_wr_y;
  cell_t      w_ink;
  logic       w_clr_en;
  cell_t      w_old;
  cell_t      w_new;

  pixel_to_cell #(
    .X0      (X0),
    .Y0      (Y0),
    .CELL_PX (CELL_PX)
  ) u_pixel_to_cell (
    .i_ball_x (BallX),
    .i_ball_y (BallY),
    .o_cx     (w_cx),
    .o_cy     (w_cy),
    .o_valid  (w_valid)
  );

  assign w_frame_rise = frame_clk & ~r_fc_q;
  assign w_stroke     = (r_state != ST_IDLE) && (r_state != ST_CLEAR);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (clear_req || r_pending)                  w_next_state = ST_CLEAR;
        else if (w_frame_rise && draw_en && w_valid) w_next_state = ST_CENTER;
      end
      ST_CLEAR:  if (r_col == 5'(CANVAS_N - 1)) w_next_state = ST_IDLE;
      ST_CENTER: w_next_state = ST_LEFT;
      ST_LEFT:   w_next_state = ST_RIGHT;
      ST_RIGHT:  w_next_state = ST_UP;
      ST_UP:     w_next_state = ST_DOWN;
      ST_DOWN:   w_next_state = (r_pending || clear_req) ? ST_CLEAR : ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Off-canvas neighbours still spend their cycle, just without a write.
  always_comb begin
    w_wr_en  = 1'b0;
    w_wr_x   = r_px;
    w_wr_y   = r_py;
    w_ink    = INK_EDGE;
    w_clr_en = 1'b0;
    case (r_state)
      ST_CLEAR:  w_clr_en = 1'b1;
      ST_CENTER: begin
        w_wr_en = 1'b1;
        w_ink   = INK_CENTER;
      end
      ST_LEFT: begin
        w_wr_en = (r_px != 5'd0);
        w_wr_x  = r_px - 5'd1;
      end
      ST_RIGHT: begin
        w_wr_en = (r_px != 5'(CANVAS_N - 1));
        w_wr_x  = r_px + 5'd1;
      end
      ST_UP: begin
        w_wr_en = (r_py != 5'd0);
        w_wr_y  = r_py - 5'd1;
      end
      ST_DOWN: begin
        w_wr_en = (r_py != 5'(CANVAS_N - 1));
        w_wr_y  = r_py + 5'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_fc_q    <= 1'b0;
      r_px      <= '0;
      r_py      <= '0;
      r_col     <= '0;
      r_pending <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_fc_q <= frame_clk;
      r_busy <= (w_next_state != ST_IDLE);
      if (r_state == ST_IDLE && w_next_state == ST_CENTER) begin
        r_px <= w_cx;
        r_py <= w_cy;
      end
      if (w_next_state == ST_CLEAR && r_state != ST_CLEAR) r_col <= '0;
      else if (r_state == ST_CLEAR)                        r_col <= r_col + 5'd1;
      if (w_next_state == ST_CLEAR)   r_pending <= 1'b0;
      else if (w_stroke && clear_req) r_pending <= 1'b1;
    end
  end

  // Single shared saturating adder: at most one cell is inked per cycle.
  assign w_old = r_canvas[w_wr_x][w_wr_y];
  assign w_new = sat_add(w_old, w_ink, INK_MAX);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      // NOTE: the canvas is a flop array read in parallel by the renderer, so it is reset
      // like any register; a RAM-mapped array would instead be cleared by the sweep.
      for (int x = 0; x < CANVAS_N; x++)
        for (int y = 0; y < CANVAS_N; y++)
          r_canvas[x][y] <= '0;
    end else if (w_clr_en) begin
      for (int y = 0; y < CANVAS_N; y++)
        r_canvas[r_col][y] <= '0;
    end else if (w_wr_en) begin
      r_canvas[w_wr_x][w_wr_y] <= w_new;
    end
  end

  assign canvas = r_canvas;
  assign busy   = r_busy;

endmodule

// File: tb/tb_canvas_painter.sv
// Directed self-checking bench for canvas_painter: stroke latency, saturation,
// edge cells, invalid cursor, deferred clear and reset during a sweep.
module tb_canvas_painter;
  import canvas_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic [9:0] BallX;
  logic [9:0] BallY;
  logic       draw_en;
  logic       clear_req;
  canvas_t    canvas;
  logic       busy;

  canvas_t exp_cv;
  int      n_total = 0;
  int      n_bad   = 0;

  always #5 Clk = ~Clk;

  canvas_painter dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .BallX     (BallX),
    .BallY     (BallY),
    .draw_en   (draw_en),
    .clear_req (clear_req),
    .canvas    (canvas),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_model();
    for (int x = 0; x < CANVAS_N; x++)
      for (int y = 0; y < CANVAS_N; y++)
        exp_cv[x][y] = '0;
  endtask

  task automatic check_canvas(input string tag);
    int mism;
    mism = 0;
    for (int x = 0; x < CANVAS_N; x++)
      for (int y = 0; y < CANVAS_N; y++)
        if (canvas[x][y] !== exp_cv[x][y]) mism++;
    check(tag, mism, 0);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    clear_model();
  endtask

  // One frame edge; returns how many sampled cycles busy stayed high.
  task automatic stroke(input logic [9:0] bx, input logic [9:0] by, input logic de,
                        output int cnt);
    BallX     = bx;
    BallY     = by;
    draw_en   = de;
    frame_clk = 1'b1;
    cnt       = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!busy) break;
      cnt++;
    end
    frame_clk = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    cell_t exp_c [3];
    cell_t exp_n [3];

    Reset = 1'b1; frame_clk = 1'b0; BallX = '0; BallY = '0;
    draw_en = 1'b0; clear_req = 1'b0;
    tick();
    do_reset();
    check("reset_busy", busy, 0);
    check_canvas("reset_canvas");

    // Stroke at (207,51) -> cell (0,0); LEFT and UP fall off the canvas.
    BallX = 10'd207; BallY = 10'd51; draw_en = 1'b1; frame_clk = 1'b1;
    tick();                                    // edge N
    check("t1_busy_N", busy, 1);
    check("t1_center_N", canvas[0][0], 16'h0000);
    tick();                                    // N+1
    check("t1_center_N1", canvas[0][0], 16'h0400);
    check("t1_right_N1", canvas[1][0], 16'h0000);
    tick(); tick();                            // N+3
    check("t1_right_N3", canvas[1][0], 16'h0100);
    check("t1_busy_N3", busy, 1);
    tick();                                    // N+4
    check("t1_busy_N4", busy, 1);
    tick();                                    // N+5
    check("t1_busy_N5", busy, 0);
    check("t1_down_N5", canvas[0][1], 16'h0100);
    frame_clk = 1'b0;
    tick();
    exp_cv[0][0] = 16'h0400; exp_cv[1][0] = 16'h0100; exp_cv[0][1] = 16'h0100;
    check_canvas("t1_canvas");

    // Same cell (1,1) three frames: center saturates, neighbours accumulate.
    do_reset();
    exp_c[0] = 16'h0400; exp_c[1] = 16'h07FF; exp_c[2] = 16'h07FF;
    exp_n[0] = 16'h0100; exp_n[1] = 16'h0200; exp_n[2] = 16'h0300;
    for (int f = 0; f < 3; f++) begin
      stroke(10'd221, 10'd65, 1'b1, cnt);
      check($sformatf("t2_busy_len_f%0d", f), cnt, 5);
      check($sformatf("t2_center_f%0d", f), canvas[1][1], exp_c[f]);
      check($sformatf("t2_left_f%0d", f), canvas[0][1], exp_n[f]);
      check($sformatf("t2_down_f%0d", f), canvas[1][2], exp_n[f]);
    end
    exp_cv[1][1] = 16'h07FF;
    exp_cv[0][1] = 16'h0300; exp_cv[2][1] = 16'h0300;
    exp_cv[1][0] = 16'h0300; exp_cv[1][2] = 16'h0300;
    check_canvas("t2_canvas");

    // Bottom-right corner cell (27,27): RIGHT and DOWN are skipped.
    stroke(10'd591, 10'd435, 1'b1, cnt);
    check("t3_busy_len", cnt, 5);
    exp_cv[27][27] = 16'h0400; exp_cv[26][27] = 16'h0100; exp_cv[27][26] = 16'h0100;
    check_canvas("t3_canvas");

    // Cursor just outside the canvas or button released: nothing happens.
    stroke(10'd199, 10'd100, 1'b1, cnt);
    check("t4_left_out_busy", cnt, 0);
    stroke(10'd592, 10'd100, 1'b1, cnt);
    check("t4_right_out_busy", cnt, 0);
    stroke(10'd300, 10'd436, 1'b1, cnt);
    check("t4_bottom_out_busy", cnt, 0);
    stroke(10'd207, 10'd51, 1'b0, cnt);
    check("t4_no_draw_busy", cnt, 0);
    check_canvas("t4_canvas");

    // Clear pulsed during UP at (200,44) -> cell (0,0); clear follows the stroke.
    BallX = 10'd200; BallY = 10'd44; draw_en = 1'b1; frame_clk = 1'b1;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();                                  // edge N+i
      if (i == 5) check("t5_down_written", canvas[0][1], 16'h0400);
      if (i == 6) begin
        check("t5_col0_cleared", canvas[0][1], 16'h0000);
        check("t5_col1_intact", canvas[1][1], 16'h07FF);
      end
      if (i == 7) check("t5_col1_cleared", canvas[1][1], 16'h0000);
      if (!busy) break;
      cnt++;
      if (i == 1)  frame_clk = 1'b0;
      if (i == 3)  clear_req = 1'b1;
      if (i == 4)  clear_req = 1'b0;
      if (i == 10) frame_clk = 1'b1;           // dropped: painter is busy
      if (i == 12) frame_clk = 1'b0;
    end
    check("t5_busy_len", cnt, 33);
    clear_model();
    check_canvas("t5_canvas");
    tick();
    check("t5_idle_after", busy, 0);

    // Reset in the middle of a sweep.
    stroke(10'd591, 10'd435, 1'b1, cnt);
    clear_req = 1'b1;
    tick();                                    // edge M
    clear_req = 1'b0;
    check("t6_busy_clear", busy, 1);
    for (int i = 0; i < 9; i++) tick();
    check("t6_col27_pending", canvas[27][27], 16'h0400);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("t6_busy_reset", busy, 0);
    clear_model();
    check_canvas("t6_canvas");
    stroke(10'd207, 10'd51, 1'b1, cnt);
    check("t6_stroke_after", cnt, 5);
    check("t6_center_after", canvas[0][0], 16'h0400);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
